// File: rtl/tri_hit_engine.sv
// Point-in-triangle engine: tests one latched point against NTRI stored triangles,
// one edge cross product per cycle on a shared pair of multipliers.
module tri_hit_engine #(
  parameter int unsigned W    = 11,
  parameter int unsigned NTRI = 4,
  parameter int unsigned IW   = $clog2(NTRI)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_tri,
  input  logic [1:0]      wr_vtx,
  input  logic [W-1:0]    wr_x,
  input  logic [W-1:0]    wr_y,
  input  logic            start,
  input  logic [W-1:0]    point_x,
  input  logic [W-1:0]    point_y,
  input  logic            inclusive,
  output logic            busy,
  output logic            done,
  output logic [NTRI-1:0] hit_mask,
  output logic            any_hit,
  output logic [IW-1:0]   first_idx
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned SW = 2 * W + 3;

  typedef enum logic [1:0] {IDLE, EDGE, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       triIdx;
  logic [1:0]          edgeIdx;
  logic [W-1:0]        pointX, pointY;
  logic                inclMode;
  logic signed [SW-1:0] d0, d1;
  logic [W-1:0]        vx [NTRI][3];
  logic [W-1:0]        vy [NTRI][3];

  logic [W-1:0]        ax, ay, bx, by;
  logic signed [DW-1:0] pxb, ayb, axb, pyb;
  logic signed [PW-1:0] prodA, prodB;
  logic signed [SW-1:0] dCur;
  logic                verdict;
  logic [IW-1:0]       lowIdx;

  // Vertex store; writes are only accepted while no test is running.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < int'(NTRI); t++) begin
        for (int v = 0; v < 3; v++) begin
          vx[t][v] <= '0;
          vy[t][v] <= '0;
        end
      end
    end else if (wr_en && !busy && wr_vtx != 2'd3 && 32'(wr_tri) < NTRI) begin
      vx[wr_tri][wr_vtx] <= wr_x;
      vy[wr_tri][wr_vtx] <= wr_y;
    end
  end

  // Edge vertex pair: (V0,V1), (V1,V2), (V2,V0).
  always_comb begin
    ax = vx[triIdx][0];
    ay = vy[triIdx][0];
    bx = vx[triIdx][1];
    by = vy[triIdx][1];
    case (edgeIdx)
      2'd1: begin
        ax = vx[triIdx][1];
        ay = vy[triIdx][1];
        bx = vx[triIdx][2];
        by = vy[triIdx][2];
      end
      2'd2: begin
        ax = vx[triIdx][2];
        ay = vy[triIdx][2];
        bx = vx[triIdx][0];
        by = vy[triIdx][0];
      end
      default: ;
    endcase
  end

  // d = (Px-Bx)*(Ay-By) - (Ax-Bx)*(Py-By), sized so no W-bit input can overflow.
  always_comb begin
    pxb   = $signed({1'b0, pointX}) - $signed({1'b0, bx});
    ayb   = $signed({1'b0, ay})     - $signed({1'b0, by});
    axb   = $signed({1'b0, ax})     - $signed({1'b0, bx});
    pyb   = $signed({1'b0, pointY}) - $signed({1'b0, by});
    prodA = PW'(pxb) * PW'(ayb);
    prodB = PW'(axb) * PW'(pyb);
    dCur  = SW'(prodA) - SW'(prodB);
  end

  // Triangle verdict from the two stored edges plus the current one.
  always_comb begin
    logic z0, z1, z2, n0, n1, n2, p0, p1, p2;
    z0 = (d0 == '0);
    z1 = (d1 == '0);
    z2 = (dCur == '0);
    n0 = d0[SW-1];
    n1 = d1[SW-1];
    n2 = dCur[SW-1];
    p0 = !n0 && !z0;
    p1 = !n1 && !z1;
    p2 = !n2 && !z2;
    if (inclMode)
      verdict = ((!n0 && !n1 && !n2) || (!p0 && !p1 && !p2)) && !(z0 && z1 && z2);
    else
      verdict = (p0 && p1 && p2) || (n0 && n1 && n2);
  end

  always_comb begin
    lowIdx = '0;
    for (int i = int'(NTRI) - 1; i >= 0; i--) begin
      if (hit_mask[i]) lowIdx = IW'(i);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      triIdx    <= '0;
      edgeIdx   <= '0;
      pointX    <= '0;
      pointY    <= '0;
      inclMode  <= 1'b0;
      d0        <= '0;
      d1        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_mask  <= '0;
      any_hit   <= 1'b0;
      first_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pointX    <= point_x;
            pointY    <= point_y;
            inclMode  <= inclusive;
            hit_mask  <= '0;
            any_hit   <= 1'b0;
            first_idx <= '0;
            triIdx    <= '0;
            edgeIdx   <= '0;
            busy      <= 1'b1;
            state     <= EDGE;
          end
        end
        EDGE: begin
          case (edgeIdx)
            2'd0: begin
              d0      <= dCur;
              edgeIdx <= 2'd1;
            end
            2'd1: begin
              d1      <= dCur;
              edgeIdx <= 2'd2;
            end
            default: begin
              hit_mask[triIdx] <= verdict;
              edgeIdx          <= 2'd0;
              if (triIdx == IW'(NTRI - 1)) state <= DONE;
              else triIdx <= triIdx + IW'(1);
            end
          endcase
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          any_hit   <= |hit_mask;
          first_idx <= lowIdx;
          triIdx    <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_hit_engine.sv
// Scoreboard bench for tri_hit_engine: a reference model predicts each test's
// hit mask when start is driven; results are popped and compared on done.
module tb_tri_hit_engine;
  localparam int W    = 11;
  localparam int NTRI = 4;
  localparam int IW   = 2;

  logic            CLK = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [IW-1:0]   wr_tri;
  logic [1:0]      wr_vtx;
  logic [W-1:0]    wr_x, wr_y;
  logic            start;
  logic [W-1:0]    point_x, point_y;
  logic            inclusive;
  logic            busy, done;
  logic [NTRI-1:0] hit_mask;
  logic            any_hit;
  logic [IW-1:0]   first_idx;

  tri_hit_engine #(.W(W), .NTRI(NTRI), .IW(IW)) dut (
    .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_tri(wr_tri), .wr_vtx(wr_vtx),
    .wr_x(wr_x), .wr_y(wr_y), .start(start), .point_x(point_x), .point_y(point_y),
    .inclusive(inclusive), .busy(busy), .done(done), .hit_mask(hit_mask),
    .any_hit(any_hit), .first_idx(first_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NTRI-1:0] mask;
    logic            anyHit;
    logic [IW-1:0]   firstIdx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  longint mx[NTRI][3];
  longint my[NTRI][3];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint edgeD(longint px, longint py, longint ax, longint ay,
                                   longint bx, longint by);
    return (px - bx) * (ay - by) - (ax - bx) * (py - by);
  endfunction

  function automatic bit modelHit(int t, longint px, longint py, bit incl);
    int pos = 0, neg = 0, zer = 0;
    for (int e = 0; e < 3; e++) begin
      longint d;
      int b;
      b = (e + 1) % 3;
      d = edgeD(px, py, mx[t][e], my[t][e], mx[t][b], my[t][b]);
      if (d > 0) pos++;
      else if (d < 0) neg++;
      else zer++;
    end
    if (zer == 3) return 1'b0;
    if (incl) return (neg == 0) || (pos == 0);
    return (pos == 3) || (neg == 3);
  endfunction

  task automatic writeVtx(input int t, input int v, input int x, input int y);
    @(negedge CLK);
    wr_en  = 1'b1;
    wr_tri = IW'(t);
    wr_vtx = 2'(v);
    wr_x   = W'(x);
    wr_y   = W'(y);
    @(negedge CLK);
    wr_en = 1'b0;
    if (v < 3) begin
      mx[t][v] = x;
      my[t][v] = y;
    end
  endtask

  task automatic writeTri(input int t, input int x0, input int y0, input int x1,
                          input int y1, input int x2, input int y2);
    writeVtx(t, 0, x0, y0);
    writeVtx(t, 1, x1, y1);
    writeVtx(t, 2, x2, y2);
  endtask

  // Drive start on a falling edge; returns once the sampling rising edge has passed.
  task automatic pushStart(input int px, input int py, input bit incl);
    exp_t e;
    e.mask = '0;
    e.firstIdx = '0;
    for (int t = NTRI - 1; t >= 0; t--) begin
      if (modelHit(t, px, py, incl)) begin
        e.mask[t]  = 1'b1;
        e.firstIdx = IW'(t);
      end
    end
    e.anyHit = |e.mask;
    sb.push_back(e);
    @(negedge CLK);
    start     = 1'b1;
    point_x   = W'(px);
    point_y   = W'(py);
    inclusive = incl;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic runTest(input string tag, input int px, input int py, input bit incl,
                         input bit interfere);
    int n = 0;
    int pulses = 0;
    exp_t e;
    pushStart(px, py, incl);
    checkVal({tag, "_busy"}, 64'(busy), 64'(1));
    while (n < 40) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      start = 1'b0;
      wr_en = 1'b0;
      if (interfere && n == 3) begin
        start   = 1'b1;
        point_x = W'(2047);
        point_y = W'(2047);
        wr_en   = 1'b1;
        wr_tri  = '0;
        wr_vtx  = 2'd0;
        wr_x    = W'(100);
        wr_y    = W'(100);
      end
      if (done) break;
    end
    start = 1'b0;
    wr_en = 1'b0;
    checkVal({tag, "_latency"}, 64'(n), 64'(3 * NTRI + 1));
    e = sb.pop_front();
    checkVal({tag, "_mask"}, 64'(hit_mask), 64'(e.mask));
    checkVal({tag, "_any"}, 64'(any_hit), 64'(e.anyHit));
    checkVal({tag, "_first"}, 64'(first_idx), 64'(e.firstIdx));
    checkVal({tag, "_busy_done"}, 64'(busy), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done) pulses++;
    end
    checkVal({tag, "_one_pulse"}, 64'(pulses), 64'(0));
    checkVal({tag, "_hold"}, 64'(hit_mask), 64'(e.mask));
  endtask

  initial begin
    int pulses;
    exp_t dummy;
    rst = 1'b0; wr_en = 1'b0; wr_tri = '0; wr_vtx = '0; wr_x = '0; wr_y = '0;
    start = 1'b0; point_x = '0; point_y = '0; inclusive = 1'b0;
    for (int t = 0; t < NTRI; t++)
      for (int v = 0; v < 3; v++) begin mx[t][v] = 0; my[t][v] = 0; end
    repeat (3) @(negedge CLK);
    checkVal("rst_busy", 64'(busy), 64'(0));
    checkVal("rst_done", 64'(done), 64'(0));
    checkVal("rst_mask", 64'(hit_mask), 64'(0));
    checkVal("rst_any", 64'(any_hit), 64'(0));
    checkVal("rst_first", 64'(first_idx), 64'(0));
    @(negedge CLK);
    rst = 1'b1;

    writeTri(0, 0, 0, 10, 0, 0, 10);
    writeTri(1, 15, 15, 30, 0, 15, 0);
    writeTri(2, 0, 0, 2047, 0, 0, 2047);
    writeTri(3, 0, 0, 5, 5, 10, 10);
    writeVtx(0, 3, 500, 500);

    runTest("p33", 3, 3, 1'b0, 1'b0);
    checkVal("p33_t0", 64'(hit_mask[0]), 64'(1));
    checkVal("p33_t1", 64'(hit_mask[1]), 64'(0));
    runTest("p205", 20, 5, 1'b0, 1'b0);
    checkVal("p205_t1", 64'(hit_mask[1]), 64'(1));
    writeTri(1, 15, 0, 30, 0, 15, 15);
    runTest("p205rev", 20, 5, 1'b0, 1'b0);
    checkVal("p205rev_t1", 64'(hit_mask[1]), 64'(1));
    runTest("p55s", 5, 5, 1'b0, 1'b0);
    checkVal("p55s_t0", 64'(hit_mask[0]), 64'(0));
    runTest("p55i", 5, 5, 1'b1, 1'b0);
    checkVal("p55i_t0", 64'(hit_mask[0]), 64'(1));
    checkVal("p55i_t3", 64'(hit_mask[3]), 64'(0));
    runTest("pmax", 2047, 2047, 1'b0, 1'b0);
    checkVal("pmax_t2", 64'(hit_mask[2]), 64'(0));
    runTest("pmaxi", 2047, 2047, 1'b1, 1'b0);
    checkVal("pmaxi_t2", 64'(hit_mask[2]), 64'(0));
    runTest("p11", 1, 1, 1'b0, 1'b0);
    checkVal("p11_t2", 64'(hit_mask[2]), 64'(1));

    // Start and vertex write during busy must not disturb the test or the store.
    runTest("busyIgn", 3, 3, 1'b0, 1'b1);
    runTest("busyIgn2", 3, 3, 1'b0, 1'b0);
    checkVal("busyIgn2_t0", 64'(hit_mask[0]), 64'(1));

    for (int i = 0; i < 6; i++)
      runTest("rand", int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of a test aborts it without a done pulse.
    pushStart(3, 3, 1'b0);
    dummy = sb.pop_front();
    repeat (4) @(posedge CLK);
    #2 rst = 1'b0;
    #1;
    checkVal("midrst_busy", 64'(busy), 64'(0));
    checkVal("midrst_done", 64'(done), 64'(0));
    checkVal("midrst_mask", 64'(hit_mask), 64'(0));
    checkVal("midrst_any", 64'(any_hit), 64'(0));
    checkVal("midrst_first", 64'(first_idx), 64'(0));
    for (int t = 0; t < NTRI; t++)
      for (int v = 0; v < 3; v++) begin mx[t][v] = 0; my[t][v] = 0; end
    @(negedge CLK);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done) pulses++;
    end
    checkVal("midrst_nodone", 64'(pulses), 64'(0));
    runTest("postrst", 3, 3, 1'b1, 1'b0);
    writeTri(0, 0, 0, 10, 0, 0, 10);
    runTest("postrst2", 3, 3, 1'b0, 1'b0);
    checkVal("postrst2_t0", 64'(hit_mask[0]), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
